dm_unit: RTL and testbench
==========================

Name: dm_unit

Overview:
- Data-memory stage that consumes the CPU's MEM-stage DM port: write enable, address, store data and DMType.
- Returns load data combinationally in the same cycle so the MEM/WB register can capture it.
- Contains byte-addressable RAM with sub-word store lane masking and load sign/zero extension.
- Also contains a small MMIO window: LED register, cycle counter, store counter and misaligned-store fault capture.

Parameters:
- DEPTH_WORDS, 1024, RAM size in 32-bit words; power of two.
- MMIO_HI, 16'hFFFF, value of Addr_in[31:16] that selects the MMIO window.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- mem_w  input  1  store enable from MEM stage.
- Addr_in  input  32  byte address (CPU aluout).
- Data_in  input  32  store data, right-aligned.
- DMType  input  3  access size/extension.
- Data_out  output  32  load data, combinational.
- led  output  16  LED register contents.
- fault  output  1  sticky misaligned-store flag.

Behaviour:
- DMType encoding:
  - 000 word
  - 001 half signed
  - 010 half unsigned
  - 011 byte signed
  - 100 byte unsigned
  - 101-111 treated as word.
- Decode: MMIO when Addr_in[31:16]==MMIO_HI, else RAM.
  - RAM word index = Addr_in[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (aliasing permitted).
- Misaligned access:
  - half with Addr_in[0]=1.
  - word with Addr_in[1:0]!=0.
- Loads are combinational:
  - Select the lane by Addr_in[1:0].
  - Extend per DMType.
  - Misaligned load returns 32'h0.
- Stores commit at posedge when mem_w=1 and aligned.
  - Byte: lane Addr_in[1:0] gets Data_in[7:0].
  - Half: lanes {Addr_in[1],0} and +1 get Data_in[15:0].
  - Word: all lanes.
  - Other lanes unchanged.
- Same-cycle read of a location being stored returns old data; the following cycle returns new data.
- Misaligned store:
  - Suppressed; no RAM or MMIO change.
  - Sets fault at the posedge.
  - If fault was 0, captures Addr_in into fault_addr; later faults do not overwrite fault_addr.
- MMIO map (offset = Addr_in[15:0]); word reads, sub-word reads use the same lane/extension rules:
  - 0x0000 LED: RW. Low 16 bits hold state, upper read 0. Stores respect lane masks on lanes 0-1; lanes 2-3 are ignored.
  - 0x0004 CYCLE: RO. 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF->0. Read returns pre-increment value.
  - 0x0008 STORES: RO. +1 per committed RAM store, not MMIO stores. Wraps.
  - 0x000C FAULT: bit0=fault, other bits 0. An aligned store with Data_in bit0=1 in lane 0 clears fault. A clear and a set in the same cycle cannot coincide, since the set requires a misaligned store; if the design ever merges them, set has priority.
  - 0x0010 FAULT_ADDR: RO.
  - Writes to RO registers are ignored.
  - Unmapped offsets read 0; writes to them are ignored and do not count as stores.
- Reset (rst=1 at posedge):
  - led=0, CYCLE=0, STORES=0, fault=0, fault_addr=0.
  - RAM contents are not cleared.
  - Stores presented during a reset cycle are discarded.
  - Reset mid-run takes effect at that edge; CYCLE reads 0 in the first cycle after reset.
- No stalls and no handshake: every access completes in its cycle, so latency is 0 for loads and 1 edge for stores.

Test Plan:
- Word store then load: store 0x12345678 @0x10; next cycle DMType=000 @0x10 -> 0x12345678. Same-cycle read before the edge -> old value.
- Sub-word stores:
  - Write byte 0xAB @0x13 over word 0x12345678 -> word reads 0xAB345678.
  - Byte signed @0x13 -> 0xFFFFFFAB; byte unsigned -> 0x000000AB.
  - Half 0x8001 @0x12 -> half signed @0x12 reads 0xFFFF8001.
- Misaligned store: word store 0xDEADBEEF @0x21 -> RAM @0x20 unchanged, fault=1, FAULT_ADDR=0x21. A second misaligned store @0x42 leaves FAULT_ADDR=0x21. Store 1 to 0xFFFF000C -> fault=0. STORES does not increment on any of these.
- LED: store half 0xBEEF @0xFFFF0000 -> led=0xBEEF. Store byte 0x12 @0xFFFF0001 -> led=0x12EF. Load word reads 0x000012EF.
- Counters: after 10 cycles from reset release, CYCLE reads 10. Force CYCLE=0xFFFFFFFF via reset-free run or force -> next cycle reads 0. Three RAM stores -> STORES=3.
- Reset mid-operation: LED=0x00FF, fault=1, then rst asserted while mem_w=1 @0x30 -> led=0, fault=0, CYCLE=0, RAM @0x30 unchanged.

Source files
------------

// File: rtl/dm_unit.sv
// Data-memory stage: byte-lane RAM with combinational load path and a small MMIO window
// (LED, cycle counter, store counter, misaligned-store fault capture).
module dm_unit #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [15:0] MMIO_HI     = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [2:0]  DMType,
    output logic [31:0] Data_out,
    output logic [15:0] led,
    output logic        fault
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [15:0] led_reg;
    logic [31:0] cycle_reg;
    logic [31:0] stores_reg;
    logic        fault_reg;
    logic [31:0] fault_addr_reg;

    logic          is_mmio;
    logic          is_half;
    logic          is_byte;
    logic          misaligned;
    logic [3:0]    lane_mask;
    logic [31:0]   wdata;
    logic          commit;
    logic          ram_we;
    logic [AW-1:0] word_idx;
    logic [13:0]   reg_sel;
    logic [31:0]   ram_rdata;
    logic [31:0]   mmio_rdata;
    logic [31:0]   rword;
    logic [31:0]   shifted;

    assign is_mmio  = (Addr_in[31:16] == MMIO_HI);
    assign is_half  = (DMType == 3'b001) || (DMType == 3'b010);
    assign is_byte  = (DMType == 3'b011) || (DMType == 3'b100);
    assign word_idx = Addr_in[AW+1:2];
    assign reg_sel  = Addr_in[15:2];

    // Anything that is neither half nor byte (including 101-111) is a word access.
    assign misaligned = (is_half && Addr_in[0]) ||
                        (!is_half && !is_byte && (Addr_in[1:0] != 2'b00));

    always_comb begin
        lane_mask = 4'b1111;
        wdata     = Data_in;
        if (is_byte) begin
            lane_mask = 4'b0001 << Addr_in[1:0];
            wdata     = {4{Data_in[7:0]}};
        end else if (is_half) begin
            lane_mask = Addr_in[1] ? 4'b1100 : 4'b0011;
            wdata     = {2{Data_in[15:0]}};
        end
    end

    assign commit = mem_w && !misaligned && !rst;
    assign ram_we = commit && !is_mmio;

    // One narrow array per byte lane so each lane can be written independently.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (ram_we && lane_mask[gi]) begin
                    mem[word_idx] <= wdata[8*gi +: 8];
                end
            end

            assign ram_rdata[8*gi +: 8] = mem[word_idx];
        end
    endgenerate

    always_comb begin
        mmio_rdata = 32'h0;
        case (reg_sel)
            14'd0:   mmio_rdata = {16'h0, led_reg};
            14'd1:   mmio_rdata = cycle_reg;
            14'd2:   mmio_rdata = stores_reg;
            14'd3:   mmio_rdata = {31'h0, fault_reg};
            14'd4:   mmio_rdata = fault_addr_reg;
            default: mmio_rdata = 32'h0;
        endcase
    end

    assign rword   = is_mmio ? mmio_rdata : ram_rdata;
    assign shifted = rword >> {Addr_in[1:0], 3'b000};

    always_comb begin
        Data_out = rword;
        if (misaligned) begin
            Data_out = 32'h0;
        end else begin
            case (DMType)
                3'b001:  Data_out = {{16{shifted[15]}}, shifted[15:0]};
                3'b010:  Data_out = {16'h0, shifted[15:0]};
                3'b011:  Data_out = {{24{shifted[7]}}, shifted[7:0]};
                3'b100:  Data_out = {24'h0, shifted[7:0]};
                default: Data_out = rword;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_reg        <= 16'h0;
            cycle_reg      <= 32'h0;
            stores_reg     <= 32'h0;
            fault_reg      <= 1'b0;
            fault_addr_reg <= 32'h0;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
            if (ram_we) begin
                stores_reg <= stores_reg + 32'd1;
            end
            // A fault set only happens on a misaligned store, which never commits,
            // so it cannot collide with the MMIO clear below.
            if (mem_w && misaligned) begin
                fault_reg <= 1'b1;
                if (!fault_reg) begin
                    fault_addr_reg <= Addr_in;
                end
            end else if (commit && is_mmio) begin
                case (reg_sel)
                    14'd0: begin
                        if (lane_mask[0]) led_reg[7:0]  <= wdata[7:0];
                        if (lane_mask[1]) led_reg[15:8] <= wdata[15:8];
                    end
                    14'd3: begin
                        if (lane_mask[0] && wdata[0]) fault_reg <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign led   = led_reg;
    assign fault = fault_reg;
endmodule

// File: tb/tb_dm_unit.sv
// Directed bench for dm_unit: a vector table for the single-cycle behaviour plus
// hand-written sequences for reset, counters and wrap-around.
module tb_dm_unit;
    logic        clk;
    logic        rst;
    logic        mem_w;
    logic [31:0] Addr_in;
    logic [31:0] Data_in;
    logic [2:0]  DMType;
    logic [31:0] Data_out;
    logic [15:0] led;
    logic        fault;

    int n_cmp;
    int n_bad;

    dm_unit dut (
        .clk      (clk),
        .rst      (rst),
        .mem_w    (mem_w),
        .Addr_in  (Addr_in),
        .Data_in  (Data_in),
        .DMType   (DMType),
        .Data_out (Data_out),
        .led      (led),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  dt;
        logic        chk;
        logic [31:0] exp_out;
        logic [15:0] exp_led;
        logic        exp_fault;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic [2:0] dt);
        @(negedge clk);
        mem_w   = mw;
        Addr_in = a;
        Data_in = d;
        DMType  = dt;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; mem_w = 1'b0; Addr_in = 32'h0; Data_in = 32'h0; DMType = 3'b000;

        //          mw    addr          data          dt    chk   exp_out       led       fault
        vecs[0]  = '{1'b1, 32'h10,       32'h12345678, 3'd0, 1'b0, 32'h0,        16'h0,    1'b0};
        vecs[1]  = '{1'b0, 32'h10,       32'h0,        3'd0, 1'b1, 32'h12345678, 16'h0,    1'b0};
        vecs[2]  = '{1'b1, 32'h13,       32'hAB,       3'd3, 1'b1, 32'h00000012, 16'h0,    1'b0};
        vecs[3]  = '{1'b0, 32'h10,       32'h0,        3'd0, 1'b1, 32'hAB345678, 16'h0,    1'b0};
        vecs[4]  = '{1'b0, 32'h13,       32'h0,        3'd3, 1'b1, 32'hFFFFFFAB, 16'h0,    1'b0};
        vecs[5]  = '{1'b0, 32'h13,       32'h0,        3'd4, 1'b1, 32'h000000AB, 16'h0,    1'b0};
        vecs[6]  = '{1'b1, 32'h12,       32'h8001,     3'd1, 1'b1, 32'hFFFFAB34, 16'h0,    1'b0};
        vecs[7]  = '{1'b0, 32'h12,       32'h0,        3'd1, 1'b1, 32'hFFFF8001, 16'h0,    1'b0};
        vecs[8]  = '{1'b0, 32'h12,       32'h0,        3'd2, 1'b1, 32'h00008001, 16'h0,    1'b0};
        vecs[9]  = '{1'b0, 32'h10,       32'h0,        3'd0, 1'b1, 32'h80015678, 16'h0,    1'b0};
        vecs[10] = '{1'b1, 32'h20,       32'h11223344, 3'd0, 1'b0, 32'h0,        16'h0,    1'b0};
        vecs[11] = '{1'b1, 32'h21,       32'hDEADBEEF, 3'd0, 1'b1, 32'h0,        16'h0,    1'b0};
        vecs[12] = '{1'b0, 32'h20,       32'h0,        3'd0, 1'b1, 32'h11223344, 16'h0,    1'b1};
        vecs[13] = '{1'b0, 32'hFFFF0010, 32'h0,        3'd0, 1'b1, 32'h21,       16'h0,    1'b1};
        vecs[14] = '{1'b1, 32'h42,       32'h0,        3'd0, 1'b1, 32'h0,        16'h0,    1'b1};
        vecs[15] = '{1'b0, 32'hFFFF0010, 32'h0,        3'd0, 1'b1, 32'h21,       16'h0,    1'b1};
        vecs[16] = '{1'b0, 32'hFFFF000C, 32'h0,        3'd0, 1'b1, 32'h1,        16'h0,    1'b1};
        vecs[17] = '{1'b1, 32'hFFFF000C, 32'h1,        3'd0, 1'b1, 32'h1,        16'h0,    1'b1};
        vecs[18] = '{1'b0, 32'hFFFF000C, 32'h0,        3'd0, 1'b1, 32'h0,        16'h0,    1'b0};
        vecs[19] = '{1'b0, 32'hFFFF0008, 32'h0,        3'd0, 1'b1, 32'd4,        16'h0,    1'b0};
        vecs[20] = '{1'b1, 32'hFFFF0000, 32'hBEEF,     3'd2, 1'b1, 32'h0,        16'h0,    1'b0};
        vecs[21] = '{1'b1, 32'hFFFF0001, 32'h12,       3'd4, 1'b1, 32'hBE,       16'hBEEF, 1'b0};
        vecs[22] = '{1'b0, 32'hFFFF0000, 32'h0,        3'd0, 1'b1, 32'h000012EF, 16'h12EF, 1'b0};
        vecs[23] = '{1'b1, 32'hFFFF0004, 32'hFFFFFFFF, 3'd0, 1'b0, 32'h0,        16'h12EF, 1'b0};
        vecs[24] = '{1'b1, 32'hFFFF0100, 32'hFFFFFFFF, 3'd0, 1'b1, 32'h0,        16'h12EF, 1'b0};
        vecs[25] = '{1'b0, 32'hFFFF0008, 32'h0,        3'd0, 1'b1, 32'd4,        16'h12EF, 1'b0};
        vecs[26] = '{1'b0, 32'hFFFF0000, 32'h0,        3'd3, 1'b1, 32'hFFFFFFEF, 16'h12EF, 1'b0};
        vecs[27] = '{1'b1, 32'h1020,     32'hCAFEF00D, 3'd0, 1'b1, 32'h11223344, 16'h12EF, 1'b0};
        vecs[28] = '{1'b0, 32'h20,       32'h0,        3'd0, 1'b1, 32'hCAFEF00D, 16'h12EF, 1'b0};
        vecs[29] = '{1'b0, 32'hFFFF0008, 32'h0,        3'd0, 1'b1, 32'd5,        16'h12EF, 1'b0};
        vecs[30] = '{1'b1, 32'h31,       32'hFFFF,     3'd1, 1'b1, 32'h0,        16'h12EF, 1'b0};
        vecs[31] = '{1'b0, 32'hFFFF0010, 32'h0,        3'd0, 1'b1, 32'h31,       16'h12EF, 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_led", {16'h0, led}, 32'h0);
        check("reset_fault", {31'h0, fault}, 32'h0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].mw, vecs[i].addr, vecs[i].data, vecs[i].dt);
            $display("vec %0d: mw=%0b addr=0x%08h data=0x%08h dt=%0d -> out=0x%08h led=0x%04h fault=%0b",
                     i, vecs[i].mw, vecs[i].addr, vecs[i].data, vecs[i].dt, Data_out, led, fault);
            if (vecs[i].chk) check($sformatf("vec%0d_out", i), Data_out, vecs[i].exp_out);
            check($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
            check($sformatf("vec%0d_fault", i), {31'h0, fault}, {31'h0, vecs[i].exp_fault});
        end

        // Reset mid-run with a store pending: LED and fault cleared, RAM kept.
        drive(1'b1, 32'hFFFF0000, 32'h00FF, 3'd2);
        drive(1'b1, 32'h30, 32'h55AA55AA, 3'd0);
        drive(1'b0, 32'h30, 32'h0, 3'd0);
        $display("pre-reset: led=0x%04h fault=%0b", led, fault);
        check("pre_reset_led", {16'h0, led}, 32'h00FF);
        check("pre_reset_fault", {31'h0, fault}, 32'h1);
        @(negedge clk);
        rst = 1'b1; mem_w = 1'b1; Addr_in = 32'h30; Data_in = 32'h0; DMType = 3'd0;
        drive(1'b0, 32'hFFFF0004, 32'h0, 3'd0);
        rst = 1'b0;
        #1;
        $display("post-reset: cycle=0x%08h led=0x%04h fault=%0b", Data_out, led, fault);
        check("post_reset_cycle", Data_out, 32'h0);
        check("post_reset_led", {16'h0, led}, 32'h0);
        check("post_reset_fault", {31'h0, fault}, 32'h0);
        drive(1'b0, 32'h30, 32'h0, 3'd0);
        $display("ram@0x30 after reset: 0x%08h", Data_out);
        check("reset_ram_kept", Data_out, 32'h55AA55AA);
        drive(1'b0, 32'hFFFF0008, 32'h0, 3'd0);
        check("post_reset_stores", Data_out, 32'h0);
        drive(1'b1, 32'h40, 32'h1, 3'd0);
        drive(1'b1, 32'h45, 32'h2, 3'd3);
        drive(1'b1, 32'h4A, 32'h3, 3'd2);
        drive(1'b0, 32'hFFFF0008, 32'h0, 3'd0);
        $display("stores after three RAM stores: %0d", Data_out);
        check("stores_three", Data_out, 32'd3);
        repeat (3) drive(1'b0, 32'h0, 32'h0, 3'd0);
        drive(1'b0, 32'hFFFF0004, 32'h0, 3'd0);
        $display("cycle after 10 cycles: %0d", Data_out);
        check("cycle_ten", Data_out, 32'd10);

        // Cycle counter wrap.
        @(negedge clk);
        force dut.cycle_reg = 32'hFFFFFFFF;
        #1;
        release dut.cycle_reg;
        mem_w = 1'b0; Addr_in = 32'hFFFF0004; DMType = 3'd0;
        #1;
        check("cycle_max", Data_out, 32'hFFFFFFFF);
        drive(1'b0, 32'hFFFF0004, 32'h0, 3'd0);
        $display("cycle after wrap: 0x%08h", Data_out);
        check("cycle_wrap", Data_out, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
